efi_cfg_bank: RTL and testbench

Parametrised, double-buffered configuration register bank for the EFI core, replacing the ad-hoc SPI input latch array. The host writes shadow registers at any time. Shadow contents are copied atomically to the live registers that drive the sync, ignition and injection blocks. The copy happens either immediately or at the next crank trigger, so that timing, dwell and pulse width never change mid-cycle. It also provides readback of shadow and status words, and write-protection of crank-geometry registers while synced.

---
 rtl/efi_cfg_pkg.sv | 30 +++
 rtl/efi_cfg_bank_if.sv | 28 ++
 rtl/efi_cfg_commit_fsm.sv | 99 +++++++++
 rtl/efi_cfg_bank.sv | 129 ++++++++++++
 tb/tb_efi_cfg_bank.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/efi_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : efi_cfg_pkg
//  Description : Shared types and constants for the EFI configuration bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package efi_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COPY  = 2'd2
    } cfg_state_t;

    localparam int REG_EN        = 0;
    localparam int REG_TOOTH_CNT = 1;
    localparam int REG_TOOTH_W   = 2;
    localparam int REG_MISSING   = 3;
    localparam int REG_TRIG_OFS  = 4;
    localparam int REG_QPR       = 5;
    localparam int REG_PHASE0    = 6;
    localparam int REG_TIMING    = 7;
    localparam int REG_DWELL     = 8;
    localparam int REG_PW0       = 9;

    // Crank-geometry registers 1..5 must not move while the synchroniser is locked.
    localparam logic [15:0] c_lock_mask_default = 16'h003E;

endpackage
`default_nettype wire

// File: rtl/efi_cfg_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : efi_cfg_bank_if
//  Description : Host write/read bus of the EFI configuration bank.
//  Revision    : 1.0 - initial release
// ============================================================================
interface efi_cfg_bank_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_err;
    logic [AW:0]   rd_addr;
    logic [DW-1:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        input  wr_err, rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        output wr_err, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/efi_cfg_commit_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : efi_cfg_commit_fsm
//  Description : Commit sequencer: immediate or trigger-aligned shadow->live
//                copy with timeout fallback and sticky timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module efi_cfg_commit_fsm
    import efi_cfg_pkg::*;
#(
    parameter int              TO_W    = 24,
    parameter logic [TO_W-1:0] TIMEOUT = 24'd8000000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic commit_req,
    input  wire logic commit_imm,
    input  wire logic trigger,
    input  wire logic synced,
    input  wire logic clr_flags,
    output logic      copy,
    output logic      armed,
    output logic      commit_done,
    output logic      to_flag
);

    localparam logic [TO_W-1:0] c_to_last = TIMEOUT - TO_W'(1);

    cfg_state_t      r_state;
    logic [TO_W-1:0] r_cnt;
    logic            r_copy;
    logic            r_armed;
    logic            r_done;
    logic            r_to_flag;
    logic            w_timeout;

    assign w_timeout = (r_cnt >= c_to_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_copy    <= 1'b0;
            r_armed   <= 1'b0;
            r_done    <= 1'b0;
            r_to_flag <= 1'b0;
        end else begin
            r_copy <= 1'b0;
            r_done <= 1'b0;
            if (clr_flags) begin
                r_to_flag <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (commit_req) begin
                        if (commit_imm || !synced) begin
                            r_state <= ST_COPY;
                            r_copy  <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ARMED;
                            r_cnt   <= '0;
                            r_armed <= 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                    if (trigger || !synced || w_timeout) begin
                        r_state <= ST_COPY;
                        r_armed <= 1'b0;
                        r_copy  <= 1'b1;
                        r_done  <= 1'b1;
                        // A trigger on the timeout cycle is an ordinary aligned commit.
                        if (!trigger && synced) begin
                            r_to_flag <= 1'b1;
                        end
                    end
                end
                ST_COPY: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    assign copy        = r_copy;
    assign armed       = r_armed;
    assign commit_done = r_done;
    assign to_flag     = r_to_flag;

endmodule
`default_nettype wire

// File: rtl/efi_cfg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : efi_cfg_bank
//  Description : Double-buffered EFI configuration register bank with
//                write protection, shadow/status readback and atomic commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module efi_cfg_bank
    import efi_cfg_pkg::*;
#(
    parameter int                     N_REGS     = 16,
    parameter int                     DW         = 16,
    parameter int                     AW         = 4,
    parameter int                     N_STAT     = 4,
    parameter logic [N_REGS*DW-1:0]   RESET_VALS = '0,
    parameter logic [N_REGS-1:0]      LOCK_MASK  = N_REGS'(c_lock_mask_default),
    parameter int                     TO_W       = 24,
    parameter logic [TO_W-1:0]        TIMEOUT    = 24'd8000000
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    efi_cfg_bank_if.slave               bus,
    input  wire logic [N_STAT*DW-1:0]   stat_in,
    input  wire logic                   commit_req,
    input  wire logic                   commit_imm,
    input  wire logic                   trigger,
    input  wire logic                   synced,
    input  wire logic                   clr_flags,
    output logic      [N_REGS*DW-1:0]   live_regs,
    output logic                        dirty,
    output logic                        armed,
    output logic                        commit_done,
    output logic                        to_flag
);

    localparam int                 c_span = 2 ** AW;
    localparam logic [c_span-1:0]  c_lock = c_span'(LOCK_MASK);

    logic [DW-1:0]        r_shadow [N_REGS];
    logic [N_REGS*DW-1:0] r_live;
    logic                 r_dirty;
    logic [DW-1:0]        r_rd_data;
    logic                 r_wr_err;
    logic                 w_copy;
    logic                 w_addr_ok;
    logic                 w_locked;
    logic                 w_wr_acc;
    logic [DW-1:0]        w_rd_next;

    assign w_addr_ok = (int'(bus.wr_addr) < N_REGS);
    assign w_locked  = c_lock[bus.wr_addr] && synced;
    assign w_wr_acc  = bus.wr_en && w_addr_ok && !w_locked;

    efi_cfg_commit_fsm #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_commit_fsm (
        .clk         (clk),
        .rst         (rst),
        .commit_req  (commit_req),
        .commit_imm  (commit_imm),
        .trigger     (trigger),
        .synced      (synced),
        .clr_flags   (clr_flags),
        .copy        (w_copy),
        .armed       (armed),
        .commit_done (commit_done),
        .to_flag     (to_flag)
    );

    // Live captures the shadow as it stood before any same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_shadow[i] <= RESET_VALS[i*DW +: DW];
            end
            r_live  <= RESET_VALS;
            r_dirty <= 1'b0;
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (w_wr_acc && (bus.wr_addr == AW'(i))) begin
                    r_shadow[i] <= bus.wr_data;
                end
            end
            if (w_copy) begin
                for (int i = 0; i < N_REGS; i++) begin
                    r_live[i*DW +: DW] <= r_shadow[i];
                end
                r_dirty <= w_wr_acc;
            end else if (w_wr_acc) begin
                r_dirty <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_next = '0;
        if (bus.rd_addr[AW]) begin
            for (int i = 0; i < N_STAT; i++) begin
                if (bus.rd_addr[AW-1:0] == AW'(i)) begin
                    w_rd_next = stat_in[i*DW +: DW];
                end
            end
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (bus.rd_addr[AW-1:0] == AW'(i)) begin
                    w_rd_next = r_shadow[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
            r_wr_err  <= 1'b0;
        end else begin
            r_rd_data <= w_rd_next;
            r_wr_err  <= bus.wr_en && !w_wr_acc;
        end
    end

    assign bus.rd_data = r_rd_data;
    assign bus.wr_err  = r_wr_err;
    assign live_regs   = r_live;
    assign dirty       = r_dirty;

endmodule
`default_nettype wire

// File: tb/tb_efi_cfg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_efi_cfg_bank
//  Description : Self-checking bench for efi_cfg_bank with a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_efi_cfg_bank;
    import efi_cfg_pkg::*;

    localparam int N_REGS = 16;
    localparam int DW     = 16;
    localparam int AW     = 4;
    localparam int N_STAT = 4;
    localparam int FW     = N_REGS * DW;
    localparam logic [FW-1:0] c_rst_vals = (FW'(60) << (1 * DW)) | (FW'(1234) << (9 * DW));

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW:0]   rd_addr;
    logic [N_STAT*DW-1:0] stat_in;
    logic commit_req, commit_imm, trigger, synced, clr_flags;

    logic [FW-1:0] live_regs, t_live;
    logic dirty, armed, commit_done, to_flag;
    logic t_dirty, t_armed, t_done, t_to;

    efi_cfg_bank_if #(.DW(DW), .AW(AW)) bus ();
    efi_cfg_bank_if #(.DW(DW), .AW(AW)) bus_t ();

    assign bus.wr_en     = wr_en;
    assign bus.wr_addr   = wr_addr;
    assign bus.wr_data   = wr_data;
    assign bus.rd_addr   = rd_addr;
    assign bus_t.wr_en   = wr_en;
    assign bus_t.wr_addr = wr_addr;
    assign bus_t.wr_data = wr_data;
    assign bus_t.rd_addr = rd_addr;

    efi_cfg_bank #(.N_REGS(N_REGS), .DW(DW), .AW(AW), .N_STAT(N_STAT),
                   .RESET_VALS(c_rst_vals)) dut (
        .clk(clk), .rst(rst), .bus(bus), .stat_in(stat_in),
        .commit_req(commit_req), .commit_imm(commit_imm), .trigger(trigger),
        .synced(synced), .clr_flags(clr_flags), .live_regs(live_regs),
        .dirty(dirty), .armed(armed), .commit_done(commit_done), .to_flag(to_flag)
    );

    // Second instance with a short timeout for the forced-commit scenarios.
    efi_cfg_bank #(.N_REGS(N_REGS), .DW(DW), .AW(AW), .N_STAT(N_STAT),
                   .RESET_VALS(c_rst_vals), .TIMEOUT(24'd100)) dut_t (
        .clk(clk), .rst(rst), .bus(bus_t), .stat_in(stat_in),
        .commit_req(commit_req), .commit_imm(commit_imm), .trigger(trigger),
        .synced(synced), .clr_flags(clr_flags), .live_regs(t_live),
        .dirty(t_dirty), .armed(t_armed), .commit_done(t_done), .to_flag(t_to)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] m_rst    [N_REGS];
    logic [DW-1:0] m_shadow [N_REGS];
    logic [DW-1:0] m_live   [N_REGS];
    logic [DW-1:0] m_stat   [N_STAT];
    logic          m_dirty;

    function automatic logic [FW-1:0] model_live_flat();
        logic [FW-1:0] f = '0;
        for (int i = 0; i < N_REGS; i++) f[i*DW +: DW] = m_live[i];
        return f;
    endfunction

    function automatic logic is_locked(int a, logic s);
        return s && (a >= 1) && (a <= 5);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_REGS; i++) begin
            m_rst[i] = '0;
        end
        m_rst[1] = 16'd60;
        m_rst[9] = 16'd1234;
        for (int i = 0; i < N_REGS; i++) begin
            m_shadow[i] = m_rst[i];
            m_live[i]   = m_rst[i];
        end
        m_dirty = 1'b0;
    endtask

    task automatic model_commit();
        for (int i = 0; i < N_REGS; i++) m_live[i] = m_shadow[i];
        m_dirty = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        if (!is_locked(a, synced)) begin
            m_shadow[a] = d;
            m_dirty     = 1'b1;
        end
    endtask

    task automatic do_read(input logic [AW:0] a);
        rd_addr = a;
        tick();
    endtask

    task automatic arm();
        commit_req = 1'b1; commit_imm = 1'b0;
        tick();
        commit_req = 1'b0;
    endtask

    task automatic reset_both();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        model_reset();
        n_cmp++;
        if ({dirty, armed, commit_done, to_flag, bus.wr_err} !== 5'b0 || bus.rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: got d/a/c/t/e=%b rd=%0d, want all 0",
                     {dirty, armed, commit_done, to_flag, bus.wr_err}, bus.rd_data);
        end
        n_cmp++;
        if (live_regs !== model_live_flat()) begin
            n_fail++;
            $display("FAIL reset_live: got %h want %h", live_regs, model_live_flat());
        end
        rst = 1'b0;
        tick();
        do_read({1'b0, 4'd1});
        n_cmp++;
        if (bus.rd_data !== 16'd60) begin
            n_fail++;
            $display("FAIL reset_read1: got %0d want 60", bus.rd_data);
        end
    endtask

    task automatic test_unsynced_commit();
        int done_cnt;
        int armed_seen;
        synced = 1'b0;
        do_write(10, 16'd427);
        n_cmp++;
        if (dirty !== 1'b1) begin
            n_fail++; $display("FAIL unsync_dirty_set: got %b want 1", dirty);
        end
        commit_req = 1'b1; commit_imm = 1'b0;
        tick();
        commit_req = 1'b0;
        done_cnt = int'(commit_done); armed_seen = int'(armed);
        n_cmp++;
        if (live_regs[10*DW +: DW] !== m_live[10]) begin
            n_fail++; $display("FAIL unsync_early: got %0d want %0d", live_regs[10*DW +: DW], m_live[10]);
        end
        tick();
        done_cnt += int'(commit_done); armed_seen += int'(armed);
        model_commit();
        n_cmp++;
        if (live_regs[10*DW +: DW] !== 16'd427 || dirty !== m_dirty) begin
            n_fail++; $display("FAIL unsync_live: got %0d dirty=%b want 427 dirty=0",
                               live_regs[10*DW +: DW], dirty);
        end
        repeat (3) begin
            tick();
            done_cnt += int'(commit_done); armed_seen += int'(armed);
        end
        n_cmp++;
        if (done_cnt !== 1 || armed_seen !== 0) begin
            n_fail++; $display("FAIL unsync_pulses: got done=%0d armed=%0d want 1/0", done_cnt, armed_seen);
        end
    endtask

    task automatic test_armed_trigger();
        int bad = 0;
        synced = 1'b1;
        do_write(11, 16'd960);
        arm();
        n_cmp++;
        if (armed !== 1'b1) begin
            n_fail++; $display("FAIL armed_set: got %b want 1", armed);
        end
        for (int c = 0; c < 500; c++) begin
            commit_req = (c == 250);
            tick();
            commit_req = 1'b0;
            if (armed !== 1'b1 || commit_done !== 1'b0 || live_regs !== model_live_flat()) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL armed_hold: got %0d bad cycles want 0", bad);
        end
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        n_cmp++;
        if (commit_done !== 1'b1 || armed !== 1'b0 || live_regs[11*DW +: DW] !== m_live[11]) begin
            n_fail++; $display("FAIL trig_copy_cycle: got done=%b armed=%b live11=%0d want 1/0/%0d",
                               commit_done, armed, live_regs[11*DW +: DW], m_live[11]);
        end
        tick();
        model_commit();
        n_cmp++;
        if (live_regs !== model_live_flat() || dirty !== 1'b0) begin
            n_fail++; $display("FAIL trig_live: got live11=%0d dirty=%b want 960/0",
                               live_regs[11*DW +: DW], dirty);
        end
    endtask

    task automatic test_lock();
        synced = 1'b1;
        do_write(2, 16'd64);
        n_cmp++;
        if (bus.wr_err !== 1'b1 || dirty !== 1'b0) begin
            n_fail++; $display("FAIL lock_err: got err=%b dirty=%b want 1/0", bus.wr_err, dirty);
        end
        do_read({1'b0, 4'd2});
        n_cmp++;
        if (bus.wr_err !== 1'b0 || bus.rd_data !== m_shadow[2]) begin
            n_fail++; $display("FAIL lock_shadow: got err=%b rd=%0d want 0/%0d", bus.wr_err, bus.rd_data, m_shadow[2]);
        end
        synced = 1'b0;
        do_write(2, 16'd64);
        n_cmp++;
        if (bus.wr_err !== 1'b0 || dirty !== 1'b1) begin
            n_fail++; $display("FAIL unlock_wr: got err=%b dirty=%b want 0/1", bus.wr_err, dirty);
        end
        do_read({1'b0, 4'd2});
        n_cmp++;
        if (bus.rd_data !== 16'd64) begin
            n_fail++; $display("FAIL unlock_read: got %0d want 64", bus.rd_data);
        end
    endtask

    task automatic test_copy_write();
        logic [DW-1:0] snap [N_REGS];
        synced = 1'b1;
        commit_req = 1'b1; commit_imm = 1'b1;
        tick();
        for (int i = 0; i < N_REGS; i++) snap[i] = m_shadow[i];
        commit_imm = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd12; wr_data = 16'd2000;
        tick();
        wr_en = 1'b0; commit_req = 1'b0;
        for (int i = 0; i < N_REGS; i++) m_live[i] = snap[i];
        m_shadow[12] = 16'd2000;
        m_dirty      = 1'b1;
        n_cmp++;
        if (live_regs !== model_live_flat() || dirty !== 1'b1) begin
            n_fail++; $display("FAIL copy_write_live: got live12=%0d dirty=%b want %0d/1",
                               live_regs[12*DW +: DW], dirty, m_live[12]);
        end
        do_read({1'b0, 4'd12});
        n_cmp++;
        if (bus.rd_data !== 16'd2000 || armed !== 1'b0 || commit_done !== 1'b0) begin
            n_fail++; $display("FAIL copy_write_after: got rd=%0d armed=%b done=%b want 2000/0/0",
                               bus.rd_data, armed, commit_done);
        end
    endtask

    task automatic test_status();
        int bad = 0;
        logic [DW-1:0] exp;
        for (int i = 0; i < N_STAT; i++) begin
            m_stat[i] = DW'($urandom);
            stat_in[i*DW +: DW] = m_stat[i];
        end
        for (int idx = 0; idx < 8; idx++) begin
            do_read({1'b1, AW'(idx)});
            exp = (idx < N_STAT) ? m_stat[idx] : '0;
            if (bus.rd_data !== exp) begin
                bad++;
                $display("FAIL status_read[%0d]: got %h want %h", idx, bus.rd_data, exp);
            end
        end
        n_cmp++;
        if (bad !== 0) n_fail++;
    endtask

    task automatic test_random();
        int a;
        logic [DW-1:0] d;
        logic exp_err;
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    synced  = 1'($urandom);
                    a       = int'($urandom_range(0, N_REGS - 1));
                    d       = DW'($urandom);
                    exp_err = is_locked(a, synced);
                    do_write(a, d);
                    n_cmp++;
                    if (bus.wr_err !== exp_err || dirty !== m_dirty) begin
                        n_fail++; $display("FAIL rnd_write a=%0d: got err=%b dirty=%b want %b/%b",
                                           a, bus.wr_err, dirty, exp_err, m_dirty);
                    end
                end
                2: begin
                    a = int'($urandom_range(0, N_REGS - 1));
                    do_read({1'b0, AW'(a)});
                    n_cmp++;
                    if (bus.rd_data !== m_shadow[a]) begin
                        n_fail++; $display("FAIL rnd_read a=%0d: got %0d want %0d", a, bus.rd_data, m_shadow[a]);
                    end
                end
                default: begin
                    synced = 1'($urandom);
                    commit_req = 1'b1; commit_imm = 1'b1;
                    tick();
                    commit_req = 1'b0; commit_imm = 1'b0;
                    tick();
                    model_commit();
                    n_cmp++;
                    if (live_regs !== model_live_flat() || dirty !== 1'b0) begin
                        n_fail++; $display("FAIL rnd_commit: got %h dirty=%b want %h/0",
                                           live_regs, dirty, model_live_flat());
                    end
                end
            endcase
        end
    endtask

    task automatic test_timeout();
        reset_both();
        synced = 1'b1;
        do_write(13, 16'd77);
        arm();
        repeat (99) tick();
        n_cmp++;
        if (t_armed !== 1'b1 || t_to !== 1'b0 || t_live !== model_live_flat()) begin
            n_fail++; $display("FAIL to_wait: got armed=%b to=%b live13=%0d want 1/0/%0d",
                               t_armed, t_to, t_live[13*DW +: DW], m_live[13]);
        end
        tick();
        n_cmp++;
        if (t_done !== 1'b1 || t_to !== 1'b1 || t_armed !== 1'b0) begin
            n_fail++; $display("FAIL to_fire: got done=%b to=%b armed=%b want 1/1/0", t_done, t_to, t_armed);
        end
        tick();
        model_commit();
        n_cmp++;
        if (t_live !== model_live_flat() || t_dirty !== 1'b0) begin
            n_fail++; $display("FAIL to_live: got live13=%0d dirty=%b want 77/0", t_live[13*DW +: DW], t_dirty);
        end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        n_cmp++;
        if (t_to !== 1'b0) begin
            n_fail++; $display("FAIL to_clear: got %b want 0", t_to);
        end
        do_write(13, 16'd88);
        arm();
        repeat (99) tick();
        trigger = 1'b1; tick(); trigger = 1'b0;
        n_cmp++;
        if (t_done !== 1'b1 || t_to !== 1'b0) begin
            n_fail++; $display("FAIL to_vs_trig: got done=%b to=%b want 1/0", t_done, t_to);
        end
        tick();
        model_commit();
        n_cmp++;
        if (t_live !== model_live_flat()) begin
            n_fail++; $display("FAIL to_vs_trig_live: got %0d want 88", t_live[13*DW +: DW]);
        end
        do_write(14, 16'd99);
        n_cmp++;
        if (t_dirty !== 1'b1 || bus_t.wr_err !== 1'b0) begin
            n_fail++; $display("FAIL to_wr14: got dirty=%b err=%b want 1/0", t_dirty, bus_t.wr_err);
        end
        arm();
        repeat (99) tick();
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        n_cmp++;
        if (t_to !== 1'b1) begin
            n_fail++; $display("FAIL to_set_wins: got %b want 1", t_to);
        end
        tick();
        model_commit();
        do_read({1'b0, 4'd13});
        n_cmp++;
        if (t_live !== model_live_flat() || bus_t.rd_data !== 16'd88) begin
            n_fail++; $display("FAIL to_final: got live14=%0d rd13=%0d want 99/88",
                               t_live[14*DW +: DW], bus_t.rd_data);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        stat_in = '0; commit_req = 1'b0; commit_imm = 1'b0; trigger = 1'b0;
        synced = 1'b0; clr_flags = 1'b0;
        test_reset();
        test_unsynced_commit();
        test_armed_trigger();
        test_lock();
        test_copy_write();
        test_status();
        test_random();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
